// File: rtl/sa_tile_scheduler.sv
// Multi-tile job sequencer: per tile issues source read, weight read, one engine pass and result write.
// Optional build macro SA_SCHED_WGT_REUSE_EN: weights fetched once for tile 0 and reused for every later tile.
module sa_tile_scheduler #(
    parameter int ADDR_W     = 32,
    parameter int TILE_BYTES = 64,
    parameter int CNT_W      = 16
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESETN,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_src_addr,
    input  logic [ADDR_W-1:0] i_wgt_addr,
    input  logic [ADDR_W-1:0] i_dst_addr,
    input  logic [31:0]       i_size_param,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic              o_irq,
    output logic [CNT_W-1:0]  o_tile_idx,
    output logic              o_rd_start,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic              i_rd_done,
    input  logic              i_rd_error,
    output logic              o_eng_start,
    input  logic              i_eng_done,
    output logic              o_wr_start,
    output logic [ADDR_W-1:0] o_wr_addr,
    input  logic              i_wr_done,
    input  logic              i_wr_error
);

    typedef enum logic [3:0] {
        IDLE, RD_SRC, W_SRC, RD_WGT, W_WGT, COMP, W_COMP, WR, W_WR, NEXT, FIN
    } state_t;

    state_t            state, next_state;
    logic [CNT_W-1:0]  tile_cnt;
    logic [ADDR_W-1:0] src_ptr, wgt_ptr, dst_ptr;
    logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
    logic              set_err;
    logic              last_tile;
    logic              unused_size_bits;

    assign unused_size_bits = ^i_size_param[31:CNT_W];
    assign last_tile        = (o_tile_idx == tile_cnt - CNT_W'(1));

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) state <= IDLE;
        else                state <= next_state;
    end

    always_comb begin
        next_state = state;
        set_err    = 1'b0;
        case (state)
            IDLE: begin
                if (i_start)
                    next_state = (i_size_param[CNT_W-1:0] == '0) ? FIN : RD_SRC;
            end
            RD_SRC: next_state = W_SRC;
            W_SRC: begin
                if (i_rd_done) begin
                    if (i_rd_error) begin
                        next_state = FIN;
                        set_err    = 1'b1;
                    end else begin
`ifdef SA_SCHED_WGT_REUSE_EN
                        next_state = (o_tile_idx == '0) ? RD_WGT : COMP;
`else
                        next_state = RD_WGT;
`endif
                    end
                end
            end
            RD_WGT: next_state = W_WGT;
            W_WGT: begin
                if (i_rd_done) begin
                    next_state = i_rd_error ? FIN : COMP;
                    set_err    = i_rd_error;
                end
            end
            COMP:   next_state = W_COMP;
            W_COMP: if (i_eng_done) next_state = WR;
            WR:     next_state = W_WR;
            W_WR: begin
                if (i_wr_done) begin
                    next_state = i_wr_error ? FIN : NEXT;
                    set_err    = i_wr_error;
                end
            end
            NEXT:    next_state = last_tile ? FIN : RD_SRC;
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Addresses show the live pointer during an issue state and hold the last command value otherwise.
    always_comb begin
        o_busy      = (state != IDLE);
        o_irq       = (state == FIN);
        o_rd_start  = (state == RD_SRC) || (state == RD_WGT);
        o_eng_start = (state == COMP);
        o_wr_start  = (state == WR);
        o_rd_addr   = rd_addr_q;
        o_wr_addr   = wr_addr_q;
        if (state == RD_SRC) o_rd_addr = src_ptr;
        if (state == RD_WGT) o_rd_addr = wgt_ptr;
        if (state == WR)     o_wr_addr = dst_ptr;
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            tile_cnt   <= '0;
            o_tile_idx <= '0;
            src_ptr    <= '0;
            wgt_ptr    <= '0;
            dst_ptr    <= '0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            o_done     <= 1'b0;
            o_error    <= 1'b0;
        end else begin
            rd_addr_q <= o_rd_addr;
            wr_addr_q <= o_wr_addr;
            if (state == IDLE && i_start) begin
                tile_cnt   <= i_size_param[CNT_W-1:0];
                o_tile_idx <= '0;
                src_ptr    <= i_src_addr;
                wgt_ptr    <= i_wgt_addr;
                dst_ptr    <= i_dst_addr;
                o_done     <= 1'b0;
                o_error    <= 1'b0;
            end
            if (state == NEXT && !last_tile) begin
                o_tile_idx <= o_tile_idx + CNT_W'(1);
                src_ptr    <= src_ptr + ADDR_W'(TILE_BYTES);
                dst_ptr    <= dst_ptr + ADDR_W'(TILE_BYTES);
`ifndef SA_SCHED_WGT_REUSE_EN
                wgt_ptr    <= wgt_ptr + ADDR_W'(TILE_BYTES);
`endif
            end
            // Later assignments win, so a zero-tile start still shows done in FIN.
            if (next_state == FIN) o_done  <= 1'b1;
            if (set_err)           o_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sa_tile_scheduler.sv
// Directed bench for sa_tile_scheduler: behavioural one-cycle-latency responders plus a command log.
module tb_sa_tile_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [31:0] i_src_addr = '0, i_wgt_addr = '0, i_dst_addr = '0, i_size_param = '0;
    logic        o_busy, o_done, o_error, o_irq;
    logic [15:0] o_tile_idx;
    logic        o_rd_start, o_eng_start, o_wr_start;
    logic [31:0] o_rd_addr, o_wr_addr;
    logic        i_rd_done = 1'b0, i_rd_error = 1'b0, i_eng_done = 1'b0;
    logic        i_wr_done = 1'b0, i_wr_error = 1'b0;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic        prev_rd = 1'b0, prev_rd_err = 1'b0, prev_eng = 1'b0, prev_wr = 1'b0;
    logic        eng_auto = 1'b1, spurious_eng = 1'b0;
    int          err_at_rd = -1;
    logic [31:0] rd_log[$], wr_log[$], exp_rd[$];
    logic [15:0] tidx_log[$];
    int          eng_count = 0, irq_count = 0, last_wr_cycle = 0, irq_cycle = 0;

    sa_tile_scheduler dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rst_n),
        .i_start      (i_start),
        .i_src_addr   (i_src_addr),
        .i_wgt_addr   (i_wgt_addr),
        .i_dst_addr   (i_dst_addr),
        .i_size_param (i_size_param),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_error      (o_error),
        .o_irq        (o_irq),
        .o_tile_idx   (o_tile_idx),
        .o_rd_start   (o_rd_start),
        .o_rd_addr    (o_rd_addr),
        .i_rd_done    (i_rd_done),
        .i_rd_error   (i_rd_error),
        .o_eng_start  (o_eng_start),
        .i_eng_done   (i_eng_done),
        .o_wr_start   (o_wr_start),
        .o_wr_addr    (o_wr_addr),
        .i_wr_done    (i_wr_done),
        .i_wr_error   (i_wr_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    // Responders answer one cycle after each command pulse, i.e. during the matching wait state.
    always @(negedge clk) begin
        i_rd_done   = prev_rd;
        i_rd_error  = prev_rd & prev_rd_err;
        i_eng_done  = (prev_eng & eng_auto) | (spurious_eng & prev_rd);
        i_wr_done   = prev_wr;
        i_wr_error  = 1'b0;
        prev_rd     = o_rd_start;
        prev_rd_err = o_rd_start && (rd_log.size() == err_at_rd);
        if (o_rd_start) rd_log.push_back(o_rd_addr);
        prev_eng = o_eng_start;
        if (o_eng_start) eng_count++;
        prev_wr = o_wr_start;
        if (o_wr_start) begin
            wr_log.push_back(o_wr_addr);
            tidx_log.push_back(o_tile_idx);
            last_wr_cycle = cycle;
        end
        if (o_irq) begin
            irq_count++;
            irq_cycle = cycle;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        rd_log.delete();
        wr_log.delete();
        tidx_log.delete();
        eng_count = 0;
        irq_count = 0;
        err_at_rd = -1;
    endtask

    // Leaves the caller at posedge+1 of the cycle after the start edge.
    task automatic apply_stimulus(input logic [31:0] src, input logic [31:0] wgt,
                                  input logic [31:0] dst, input logic [31:0] size, input bit hold);
        @(negedge clk);
        i_src_addr   = src;
        i_wgt_addr   = wgt;
        i_dst_addr   = dst;
        i_size_param = size;
        i_start      = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) i_start = 1'b0;
    endtask

    task automatic wait_irq(input int max_cycles);
        int n = 0;
        int base = irq_count;
        while (irq_count == base && n < max_cycles) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_output("irq_timeout", 32'(irq_count != base), 32'd1);
    endtask

    task automatic settle();
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
    endtask

    initial begin
        $display("[TB] start");
        #12;
        check_output("rst_busy", 32'(o_busy), 0);
        check_output("rst_done", 32'(o_done), 0);
        check_output("rst_irq", 32'(o_irq), 0);
        check_output("rst_rd_addr", o_rd_addr, 0);
        check_output("rst_tile_idx", 32'(o_tile_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single tile with basic latency checks.
        clear_log();
        apply_stimulus(32'h1000, 32'h2000, 32'h3000, 32'd1, 1'b0);
        check_output("t1_rd_start_lat", 32'(o_rd_start), 1);
        check_output("t1_busy_lat", 32'(o_busy), 1);
        check_output("t1_rd_addr", o_rd_addr, 32'h1000);
        wait_irq(100);
        settle();
        check_output("t1_rd_count", 32'(rd_log.size()), 2);
        check_output("t1_rd0", rd_log[0], 32'h1000);
        check_output("t1_rd1", rd_log[1], 32'h2000);
        check_output("t1_eng", 32'(eng_count), 1);
        check_output("t1_wr_count", 32'(wr_log.size()), 1);
        check_output("t1_wr0", wr_log[0], 32'h3000);
        check_output("t1_irq", 32'(irq_count), 1);
        check_output("t1_irq_lat", 32'(irq_cycle - last_wr_cycle), 3);
        check_output("t1_done", 32'(o_done), 1);
        check_output("t1_error", 32'(o_error), 0);
        check_output("t1_idle", 32'(o_busy), 0);

        // Three tiles, address stepping.
        clear_log();
        exp_rd.delete();
`ifdef SA_SCHED_WGT_REUSE_EN
        exp_rd = '{32'h1000, 32'h2000, 32'h1040, 32'h1080};
`else
        exp_rd = '{32'h1000, 32'h2000, 32'h1040, 32'h2040, 32'h1080, 32'h2080};
`endif
        apply_stimulus(32'h1000, 32'h2000, 32'h3000, 32'd3, 1'b0);
        wait_irq(200);
        settle();
        check_output("t3_rd_count", 32'(rd_log.size()), 32'(exp_rd.size()));
        for (int i = 0; i < exp_rd.size(); i++)
            check_output($sformatf("t3_rd%0d", i), rd_log[i], exp_rd[i]);
        check_output("t3_eng", 32'(eng_count), 3);
        check_output("t3_wr_count", 32'(wr_log.size()), 3);
        for (int i = 0; i < 3; i++) begin
            check_output($sformatf("t3_wr%0d", i), wr_log[i], 32'h3000 + 32'(i * 64));
            check_output($sformatf("t3_tidx%0d", i), 32'(tidx_log[i]), 32'(i));
        end

        // Read error on the second source read (third read issued).
        clear_log();
        err_at_rd = 2;
        apply_stimulus(32'h1000, 32'h2000, 32'h3000, 32'd2, 1'b0);
        wait_irq(200);
        settle();
        check_output("err_rd_count", 32'(rd_log.size()), 3);
        check_output("err_eng", 32'(eng_count), 1);
        check_output("err_wr_count", 32'(wr_log.size()), 1);
        check_output("err_irq", 32'(irq_count), 1);
        check_output("err_error", 32'(o_error), 1);
        check_output("err_done", 32'(o_done), 1);
        clear_log();
        apply_stimulus(32'h1000, 32'h2000, 32'h3000, 32'd1, 1'b0);
        check_output("err_clr_done", 32'(o_done), 0);
        check_output("err_clr_error", 32'(o_error), 0);
        wait_irq(100);
        settle();
        check_output("err_after_done", 32'(o_done), 1);
        check_output("err_after_error", 32'(o_error), 0);

        // Zero-tile job.
        clear_log();
        apply_stimulus(32'h1000, 32'h2000, 32'h3000, 32'h00010000, 1'b0);
        check_output("n0_irq", 32'(o_irq), 1);
        check_output("n0_busy", 32'(o_busy), 1);
        check_output("n0_done", 32'(o_done), 1);
        @(posedge clk);
        #1;
        check_output("n0_busy_off", 32'(o_busy), 0);
        check_output("n0_irq_off", 32'(o_irq), 0);
        settle();
        check_output("n0_cmds", 32'(rd_log.size() + wr_log.size() + eng_count), 0);

        // Destination wrap.
        clear_log();
        apply_stimulus(32'h1000, 32'h2000, 32'hFFFFFFC0, 32'd2, 1'b0);
        wait_irq(200);
        settle();
        check_output("wrap_wr0", wr_log[0], 32'hFFFFFFC0);
        check_output("wrap_wr1", wr_log[1], 32'h00000000);

        // Start held high and a spurious engine done while waiting on reads.
        clear_log();
        spurious_eng = 1'b1;
        apply_stimulus(32'h1000, 32'h2000, 32'h3000, 32'd1, 1'b1);
        wait_irq(100);
        settle();
        spurious_eng = 1'b0;
        check_output("hold_rd_count", 32'(rd_log.size()), 2);
        check_output("hold_eng", 32'(eng_count), 1);
        check_output("hold_wr", wr_log[0], 32'h3000);
        check_output("hold_irq", 32'(irq_count), 1);

        // Reset while waiting on the engine.
        clear_log();
        eng_auto = 1'b0;
        apply_stimulus(32'h1000, 32'h2000, 32'h3000, 32'd1, 1'b0);
        for (int n = 0; n < 50 && eng_count == 0; n++) @(negedge clk);
        check_output("rst_mid_reach", 32'(eng_count), 1);
        @(posedge clk);
        #2;
        check_output("rst_mid_busy_pre", 32'(o_busy), 1);
        rst_n = 1'b0;
        #1;
        check_output("rst_mid_busy", 32'(o_busy), 0);
        check_output("rst_mid_rd_addr", o_rd_addr, 0);
        check_output("rst_mid_tile", 32'(o_tile_idx), 0);
        check_output("rst_mid_cmds", 32'({o_rd_start, o_eng_start, o_wr_start, o_irq}), 0);
        @(negedge clk);
        rst_n    = 1'b1;
        eng_auto = 1'b1;
        clear_log();
        settle();
        check_output("rst_mid_idle", 32'(o_busy) + 32'(rd_log.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
